axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI3 slave memory model that sits directly downstream of the CPU core's single AXI master port.
- Turns the core's read and write bursts into accesses to a word-addressed on-chip SRAM array.
- Used as the main-memory backing store in simulation and FPGA bring-up.
- Read and write channels run independent state machines, so one read burst and one write burst can be in flight at the same time.

Parameters:
- MEM_AW, 16: log2 of the memory depth in 32-bit words. Word index is addr[MEM_AW+1:2]; higher address bits are ignored, so addresses wrap modulo the depth.
- ID_W, 4: AXI ID width.
- INIT_FILE, "": when non-empty, memory is preloaded with $readmemh at elaboration.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- ar_id  in  ID_W  read request ID
- ar_addr  in  32  read byte address
- ar_len  in  8  read beats minus 1
- ar_valid  in  1  read request valid
- ar_ready  out  1  read request accepted
- r_id  out  ID_W  read data ID
- r_data  out  32  read data
- r_resp  out  2  read response, always 2'b00
- r_last  out  1  final read beat
- r_valid  out  1  read data valid
- r_ready  in  1  master accepts read data
- aw_id  in  ID_W  write request ID
- aw_addr  in  32  write byte address
- aw_len  in  8  write beats minus 1
- aw_valid  in  1  write request valid
- aw_ready  out  1  write request accepted
- w_data  in  32  write data
- w_strb  in  4  byte enables
- w_last  in  1  master's final-beat flag
- w_valid  in  1  write data valid
- w_ready  out  1  slave accepts write data
- b_id  out  ID_W  write response ID
- b_resp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- b_valid  out  1  write response valid
- b_ready  in  1  master accepts write response

Behaviour:
- Clocking and reset:
  - One clock, clock. reset is synchronous and active-high.
  - While reset is high and in the cycle after it, all outputs are 0: ar_ready, aw_ready, w_ready, r_valid, r_last, b_valid, r_data, r_resp, r_id, b_id and b_resp.
  - Memory contents are not reset.
- Read FSM (R_IDLE, R_BURST):
  - R_IDLE drives ar_ready=1. An ar handshake in cycle T latches ID, word index and ar_len+1 as the beat count, then moves to R_BURST.
  - The SRAM read is synchronous; the first r_valid appears at T+1.
  - A beat completes on r_valid&&r_ready. The index then increments by 1 (INCR only, size fixed at 4 bytes) and the next beat is presented in the following cycle, giving a sustained 1 beat/cycle.
  - r_last=1 only on the final beat. Completing the final beat returns the FSM to R_IDLE, with ar_ready=1 in the next cycle.
  - While r_valid=1 and r_ready=0, r_data, r_id and r_last hold stable.
- Write FSM (W_IDLE, W_DATA, W_RESP):
  - W_IDLE drives aw_ready=1. An aw handshake latches ID, index and beat count, then moves to W_DATA.
  - W_DATA drives w_ready=1. Each w handshake writes the bytes selected by w_strb to the current word; the index increments; the count decrements.
  - An error flag is set if w_last=1 on a non-final beat, or w_last=0 on the final beat. Writes are still performed.
  - After the final counted beat, the FSM goes to W_RESP: b_valid=1, b_resp=err?2'b10:2'b00, b_id=latched ID.
  - The b handshake clears the error flag and returns the FSM to W_IDLE.
  - Write data before an aw handshake is not accepted (w_ready=0 in W_IDLE).
- Read/write collision: a read and a write to the same word in the same cycle return the old data to the read. The write lands and is visible to reads issued in later cycles.
- Boundaries:
  - ar_len=255 gives 256 beats; the count is 9 bits.
  - An index that wraps past depth-1 continues at 0.
  - Reset asserted mid-burst aborts both FSMs to their idle states with no response issued. Partial writes already performed remain in memory.

Optional Feature:
- Macro: AXI_SLAVE_STALL_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, reloaded on reset) steps every cycle.
  - When lfsr[1:0]==2'b00, the block holds r_valid at 0 for a beat that is not yet presented, and forces w_ready=0 and ar_ready=0.
  - Handshake rules still hold: once r_valid=1 it stays 1 until accepted.
- When undefined: no stalls; the LFSR logic is absent.

Test Plan:
- Reset then idle → all outputs 0 during reset; ar_ready=aw_ready=1 one cycle after reset deasserts; w_ready=0.
- Write len=3 to 0x100 with data 11,22,33,44, strb 4'hF, w_last on beat 4 → b_resp=00 with matching b_id. Then read len=3 at 0x100 → r_data 11,22,33,44, first r_valid one cycle after the ar handshake, r_last on beat 4 only.
- Write 0xAABBCCDD to 0x200, then len=0 write 0x11223344 with strb 4'b0101 → read returns 0xAA22CC44.
- Read len=7 with r_ready toggled 1,0,0,1,... → every r_data held stable while r_valid&&!r_ready; 8 beats in order; no beat lost or repeated.
- Write len=1 with w_last=1 on beat 1 → both beats written; b_resp=2'b10. The next clean write → b_resp=2'b00.
- Read len=3 at word depth-2 → data from words depth-2, depth-1, 0, 1. Concurrently, write to word 5 while a read of word 5 issues in the same cycle → read returns old data.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 slave that backs the core's AXI master with a word-addressed SRAM.
// Latency: first R beat the cycle after the AR handshake, then 1 beat/cycle; B the cycle after the last W beat.
// Backpressure: R payload holds while r_ready=0; B holds until b_ready; AXI_SLAVE_STALL_EN adds random stalls.
//
// Ports: clock/reset (synchronous, active-high); AR/R read channels (ar_id, ar_addr, ar_len,
// ar_valid/ar_ready, r_id, r_data, r_resp, r_last, r_valid/r_ready); AW/W/B write channels
// (aw_id, aw_addr, aw_len, aw_valid/aw_ready, w_data, w_strb, w_last, w_valid/w_ready,
// b_id, b_resp, b_valid/b_ready). Optional macro: AXI_SLAVE_STALL_EN.
module axi_sram_slave #(
    parameter int    MEM_AW    = 16,
    parameter int    ID_W      = 4,
    parameter string INIT_FILE = ""
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [ID_W-1:0] ar_id,
    input  logic [31:0]     ar_addr,
    input  logic [7:0]      ar_len,
    input  logic            ar_valid,
    output logic            ar_ready,
    output logic [ID_W-1:0] r_id,
    output logic [31:0]     r_data,
    output logic [1:0]      r_resp,
    output logic            r_last,
    output logic            r_valid,
    input  logic            r_ready,
    input  logic [ID_W-1:0] aw_id,
    input  logic [31:0]     aw_addr,
    input  logic [7:0]      aw_len,
    input  logic            aw_valid,
    output logic            aw_ready,
    input  logic [31:0]     w_data,
    input  logic [3:0]      w_strb,
    input  logic            w_last,
    input  logic            w_valid,
    output logic            w_ready,
    output logic [ID_W-1:0] b_id,
    output logic [1:0]      b_resp,
    output logic            b_valid,
    input  logic            b_ready
);

    localparam int                DEPTH   = 1 << MEM_AW;
    localparam logic [MEM_AW-1:0] IDX_ONE = MEM_AW'(1);
    localparam logic [8:0]        CNT_ONE = 9'd1;

    typedef enum logic       {R_IDLE, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH];

    // Address bits outside the word index are deliberately ignored (depth wraps).
    logic [MEM_AW-1:0] ar_word, aw_word;
    logic              unused_addr_bits;
    assign ar_word = ar_addr[MEM_AW+1:2];
    assign aw_word = aw_addr[MEM_AW+1:2];
    assign unused_addr_bits = ^{ar_addr[31:MEM_AW+2], ar_addr[1:0],
                                aw_addr[31:MEM_AW+2], aw_addr[1:0]};

    logic stall;
`ifdef AXI_SLAVE_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clock) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // ---------------- read channel ----------------
    r_state_t          r_state;
    logic              ar_ready_q;
    logic [MEM_AW-1:0] r_idx;
    logic [8:0]        r_left;      // beats not yet presented on R
    logic              ar_fire, r_fire;

    assign ar_ready = ar_ready_q && !stall;
    assign ar_fire  = ar_valid && ar_ready;
    assign r_fire   = r_valid && r_ready;
    assign r_resp   = 2'b00;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= R_IDLE;
            ar_ready_q <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_data     <= '0;
            r_id       <= '0;
            r_idx      <= '0;
            r_left     <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    ar_ready_q <= 1'b1;
                    if (ar_fire) begin
                        // First beat is read straight from the request address.
                        ar_ready_q <= 1'b0;
                        r_id       <= ar_id;
                        r_data     <= mem[ar_word];
                        r_valid    <= 1'b1;
                        r_last     <= (ar_len == 8'd0);
                        r_idx      <= ar_word + IDX_ONE;
                        r_left     <= {1'b0, ar_len};
                        r_state    <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (r_fire && r_last) begin
                        r_valid    <= 1'b0;
                        r_last     <= 1'b0;
                        ar_ready_q <= 1'b1;
                        r_state    <= R_IDLE;
                    end else if ((!r_valid || r_ready) && r_left != 9'd0 && !stall) begin
                        // Slot is free (or being freed): present the next beat.
                        r_data  <= mem[r_idx];
                        r_valid <= 1'b1;
                        r_last  <= (r_left == CNT_ONE);
                        r_idx   <= r_idx + IDX_ONE;
                        r_left  <= r_left - CNT_ONE;
                    end else if (r_fire) begin
                        r_valid <= 1'b0;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- write channel ----------------
    w_state_t          w_state;
    logic              aw_ready_q, w_ready_q, w_err;
    logic [ID_W-1:0]   w_id;
    logic [MEM_AW-1:0] w_idx;
    logic [8:0]        w_cnt;       // beats still expected on W
    logic              aw_fire, w_fire, w_final, beat_err;

    assign aw_ready = aw_ready_q;
    assign w_ready  = w_ready_q && !stall;
    assign aw_fire  = aw_valid && aw_ready;
    assign w_fire   = w_valid && w_ready;
    assign w_final  = (w_cnt == CNT_ONE);
    assign beat_err = (w_last != w_final);   // w_last early or missing

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state    <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            w_err      <= 1'b0;
            w_id       <= '0;
            w_idx      <= '0;
            w_cnt      <= '0;
            b_valid    <= 1'b0;
            b_id       <= '0;
            b_resp     <= 2'b00;
        end else begin
            case (w_state)
                W_IDLE: begin
                    aw_ready_q <= 1'b1;
                    if (aw_fire) begin
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b1;
                        w_id       <= aw_id;
                        w_idx      <= aw_word;
                        w_cnt      <= {1'b0, aw_len} + CNT_ONE;
                        w_state    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_idx <= w_idx + IDX_ONE;
                        w_cnt <= w_cnt - CNT_ONE;
                        if (w_final) begin
                            w_ready_q <= 1'b0;
                            b_valid   <= 1'b1;
                            b_id      <= w_id;
                            b_resp    <= (w_err || beat_err) ? 2'b10 : 2'b00;
                            w_state   <= W_RESP;
                        end else begin
                            w_err <= w_err || beat_err;
                        end
                    end
                end
                W_RESP: begin
                    if (b_valid && b_ready) begin
                        b_valid    <= 1'b0;
                        w_err      <= 1'b0;
                        aw_ready_q <= 1'b1;
                        w_state    <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Memory is not reset; a same-edge read of this word sees the old value.
    always_ff @(posedge clock) begin
        if (w_fire && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed bench for axi_sram_slave with hand-computed expectations.
// Latency: drives inputs and samples outputs 1 time unit after each rising edge.
// Backpressure: exercises r_ready toggling; all waits on the DUT are cycle-bounded.
module tb_axi_sram_slave;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  ar_id, aw_id, r_id, b_id;
    logic [31:0] ar_addr, aw_addr, r_data, w_data;
    logic [7:0]  ar_len, aw_len;
    logic        ar_valid, ar_ready, r_last, r_valid, r_ready;
    logic [1:0]  r_resp, b_resp;
    logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
    logic [3:0]  w_strb;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wd   [16];
    logic [3:0]  ws   [16];
    logic [31:0] xd   [16];
    logic [1:0]  resp;
    logic [3:0]  bid;

    axi_sram_slave dut (
        .clock(clock), .reset(reset),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s: timed out waiting for DUT", tag);
    endtask

    // Write burst of n beats from wd/ws; w_last asserted on beat index last_at.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int n,
                            input int last_at, input string tag,
                            output logic [1:0] o_resp, output logic [3:0] o_id);
        int t;
        o_resp = 2'bxx;
        o_id   = 4'hx;
        aw_id = id; aw_addr = addr; aw_len = 8'(n - 1); aw_valid = 1'b1;
        t = 0;
        while (aw_ready !== 1'b1 && t < 20) begin step(); t++; end
        if (t == 20) timeout({tag, "_aw"});
        step();
        aw_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            w_valid = 1'b1; w_data = wd[i]; w_strb = ws[i]; w_last = (i == last_at);
            t = 0;
            while (w_ready !== 1'b1 && t < 20) begin step(); t++; end
            if (t == 20) timeout({tag, "_w"});
            step();
        end
        w_valid = 1'b0; w_last = 1'b0;
        t = 0;
        while (b_valid !== 1'b1 && t < 20) begin step(); t++; end
        if (t == 20) timeout({tag, "_b"});
        o_resp = b_resp;
        o_id   = b_id;
        b_ready = 1'b1;
        step();
        b_ready = 1'b0;
    endtask

    // Read burst of n beats, checking each presented beat against xd; r_ready follows pat.
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int n,
                           input logic [3:0] pat, input string tag);
        int t, beat, cyc;
        ar_id = id; ar_addr = addr; ar_len = 8'(n - 1); ar_valid = 1'b1;
        t = 0;
        while (ar_ready !== 1'b1 && t < 20) begin step(); t++; end
        if (t == 20) timeout({tag, "_ar"});
        step();
        ar_valid = 1'b0;
        check({tag, "_lat"}, {31'd0, r_valid}, 32'd1);
        beat = 0; cyc = 0;
        while (beat < n && cyc < 200) begin
            r_ready = pat[cyc % 4];
            if (r_valid === 1'b1) begin
                check($sformatf("%s_d%0d", tag, beat), r_data, xd[beat]);
                check($sformatf("%s_l%0d", tag, beat), {31'd0, r_last}, {31'd0, beat == n - 1});
                check($sformatf("%s_i%0d", tag, beat), {28'd0, r_id}, {28'd0, id});
                if (r_ready) beat++;
            end
            step();
            cyc++;
        end
        r_ready = 1'b0;
        if (beat < n) timeout({tag, "_r"});
        check({tag, "_done"}, {30'd0, r_valid, ar_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, beat, lastpos;
        reset = 1'b1;
        ar_id = '0; ar_addr = '0; ar_len = '0; ar_valid = 1'b0; r_ready = 1'b0;
        aw_id = '0; aw_addr = '0; aw_len = '0; aw_valid = 1'b0;
        w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;

        // Reset: outputs 0 while asserted and for the cycle after.
        step(); step();
        check("rst_ctl", {26'd0, ar_ready, aw_ready, w_ready, r_valid, r_last, b_valid}, 32'd0);
        check("rst_dat", r_data, 32'd0);
        check("rst_ids", {24'd0, r_id, b_id}, 32'd0);
        check("rst_rsp", {28'd0, r_resp, b_resp}, 32'd0);
        reset = 1'b0;
        check("post_rst_ctl", {26'd0, ar_ready, aw_ready, w_ready, r_valid, r_last, b_valid}, 32'd0);
        step();
        check("idle_rdy", {29'd0, ar_ready, aw_ready, w_ready}, 32'b110);

        // Basic 4-beat write then read back.
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(4'd3, 32'h100, 4, 3, "wr1", resp, bid);
        check("wr1_bresp", {30'd0, resp}, 32'd0);
        check("wr1_bid", {28'd0, bid}, 32'd3);
        xd[0] = 32'h11; xd[1] = 32'h22; xd[2] = 32'h33; xd[3] = 32'h44;
        do_read(4'd5, 32'h100, 4, 4'b1111, "rd1");

        // Byte strobes.
        wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
        do_write(4'd1, 32'h200, 1, 0, "wr2a", resp, bid);
        wd[0] = 32'h11223344; ws[0] = 4'b0101;
        do_write(4'd2, 32'h200, 1, 0, "wr2b", resp, bid);
        check("wr2b_bid", {28'd0, bid}, 32'd2);
        xd[0] = 32'hAA22CC44;
        do_read(4'd6, 32'h200, 1, 4'b1111, "rd2");

        // 8-beat read under r_ready backpressure 1,0,0,1,...
        for (int i = 0; i < 8; i++) begin wd[i] = 32'hC000_0000 + 32'(i * 17); ws[i] = 4'hF; end
        do_write(4'd4, 32'h300, 8, 7, "wr3", resp, bid);
        check("wr3_bresp", {30'd0, resp}, 32'd0);
        for (int i = 0; i < 8; i++) xd[i] = 32'hC000_0000 + 32'(i * 17);
        do_read(4'd9, 32'h300, 8, 4'b1001, "rd3");

        // Early w_last -> SLVERR, data still written; next clean write is OKAY.
        wd[0] = 32'hE0E0E0E0; wd[1] = 32'hE1E1E1E1; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(4'd7, 32'h400, 2, 0, "wr4", resp, bid);
        check("wr4_bresp", {30'd0, resp}, 32'd2);
        check("wr4_bid", {28'd0, bid}, 32'd7);
        xd[0] = 32'hE0E0E0E0; xd[1] = 32'hE1E1E1E1;
        do_read(4'd1, 32'h400, 2, 4'b1111, "rd4");
        wd[0] = 32'h0000_0BAD; ws[0] = 4'hF;
        do_write(4'd8, 32'h410, 1, 0, "wr5", resp, bid);
        check("wr5_bresp", {30'd0, resp}, 32'd0);

        // Wrap past depth-1 (words 65534, 65535, 0, 1); read uses high address bits.
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hD000_0000 + 32'(i); ws[i] = 4'hF; end
        do_write(4'd2, 32'h0003_FFF8, 4, 3, "wr6", resp, bid);
        for (int i = 0; i < 4; i++) xd[i] = 32'hD000_0000 + 32'(i);
        do_read(4'd3, 32'h1003_FFF8, 4, 4'b1111, "rd6");

        // Read/write collision on word 5: read sees old data.
        wd[0] = 32'h5555_5555; ws[0] = 4'hF;
        do_write(4'd0, 32'h14, 1, 0, "wr7", resp, bid);
        aw_id = 4'd6; aw_addr = 32'h14; aw_len = 8'd0; aw_valid = 1'b1;
        t = 0;
        while (aw_ready !== 1'b1 && t < 20) begin step(); t++; end
        if (t == 20) timeout("col_aw");
        step();
        aw_valid = 1'b0;
        check("col_pre", {30'd0, ar_ready, w_ready}, 32'b11);
        w_valid = 1'b1; w_data = 32'h6666_6666; w_strb = 4'hF; w_last = 1'b1;
        ar_valid = 1'b1; ar_id = 4'd10; ar_addr = 32'h14; ar_len = 8'd0;
        step();
        w_valid = 1'b0; w_last = 1'b0; ar_valid = 1'b0;
        check("col_rvld", {30'd0, r_valid, r_last}, 32'b11);
        check("col_old", r_data, 32'h5555_5555);
        check("col_b", {28'd0, b_valid, 1'b0, b_resp}, 32'b1000);
        r_ready = 1'b1; b_ready = 1'b1;
        step();
        r_ready = 1'b0; b_ready = 1'b0;
        xd[0] = 32'h6666_6666;
        do_read(4'd11, 32'h14, 1, 4'b1111, "col_new");

        // 256-beat read: r_last exactly on beat 255.
        ar_id = 4'd12; ar_addr = 32'h0; ar_len = 8'd255; ar_valid = 1'b1;
        t = 0;
        while (ar_ready !== 1'b1 && t < 20) begin step(); t++; end
        if (t == 20) timeout("len256_ar");
        step();
        ar_valid = 1'b0; r_ready = 1'b1;
        beat = 0; lastpos = -1; t = 0;
        while (beat < 256 && t < 400) begin
            if (r_valid === 1'b1) begin
                if (r_last === 1'b1 && lastpos < 0) lastpos = beat;
                beat++;
            end
            step();
            t++;
        end
        r_ready = 1'b0;
        check("len256_beats", 32'(beat), 32'd256);
        check("len256_last", 32'(lastpos), 32'd255);
        check("len256_idle", {31'd0, r_valid}, 32'd0);

        // Reset mid write burst: no response, partial data kept.
        aw_id = 4'd13; aw_addr = 32'h500; aw_len = 8'd3; aw_valid = 1'b1;
        t = 0;
        while (aw_ready !== 1'b1 && t < 20) begin step(); t++; end
        if (t == 20) timeout("mid_aw");
        step();
        aw_valid = 1'b0;
        w_valid = 1'b1; w_strb = 4'hF; w_last = 1'b0; w_data = 32'hA0;
        step();
        w_data = 32'hA1;
        step();
        w_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst", {29'd0, b_valid, w_ready, aw_ready}, 32'd0);
        step();
        check("mid_idle", {29'd0, b_valid, w_ready, aw_ready}, 32'b001);
        xd[0] = 32'hA0; xd[1] = 32'hA1;
        do_read(4'd14, 32'h500, 2, 4'b1111, "mid_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
